// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial word deserializer.
// The DESER_PARITY_EN build adds a PAR state that waits for a trailing parity bit.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PAR  = 2'd2
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    // The counter has to reach n itself, so it needs clog2(n+1) bits.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/deser_shift_core.sv
// Shift register, bit counter and direction latch for the deserializer.
// word is the value that includes the bit accepted on this edge, so completion can use it directly.
module deser_shift_core
    import deser_pkg::*;
#(
    parameter int n = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         shift_en,
    input  logic         restart,
    input  logic         ser_in,
    input  logic         dir,
    output logic [n-1:0] word,
    output logic         cnt_done
);

    localparam int CW = cnt_width(n);

    logic [n-1:0]  shreg;
    logic [n-1:0]  base;
    logic [n-1:0]  word_next;
    logic [CW-1:0] cnt;
    logic          dir_q;
    logic          dir_eff;

    // NOTE: every signal written in an always_comb gets a value on every path; otherwise a latch is inferred.
    always_comb begin
        base      = restart ? '0 : shreg;
        dir_eff   = restart ? dir : dir_q;
        word_next = (dir_eff == DIR_MSB_FIRST) ? {base[n-2:0], ser_in}
                                                : {ser_in, base[n-1:1]};
        word      = shift_en ? word_next : shreg;
        cnt_done  = shift_en && !restart && (cnt == CW'(n - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            cnt   <= '0;
            dir_q <= DIR_LSB_FIRST;
        end else if (shift_en) begin
            shreg <= word_next;
            cnt   <= restart ? CW'(1) : cnt + CW'(1);
            if (restart) begin
                dir_q <= dir;
            end
        end
    end

endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-in/parallel-out receiver with a one-deep valid/ready output buffer.
// Define DESER_PARITY_EN to require an even-parity bit after each word and add the parity_err output.
module serial_word_deserializer
    import deser_pkg::*;
#(
    parameter int n = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ser_en,
    input  logic         ser_in,
    input  logic         ser_start,
    input  logic         dir,
    input  logic         out_ready,
    input  logic         clr_ovr,
    output logic [n-1:0] out_data,
    output logic         out_valid,
    output logic         overrun,
    output logic         frame_err,
`ifdef DESER_PARITY_EN
    output logic         parity_err,
`endif
    output logic         busy
);

    state_t       state;
    logic         restart;
    logic         shift_en;
    logic         cnt_done;
    logic         deliver;
    logic [n-1:0] word;

    // A start bit is always accepted; data bits only while a word is open.
    assign restart  = ser_en && ser_start;
    assign shift_en = ser_en && (ser_start || (state == RECV));
    assign busy     = (state != IDLE);

    deser_shift_core #(.n(n)) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .shift_en (shift_en),
        .restart  (restart),
        .ser_in   (ser_in),
        .dir      (dir),
        .word     (word),
        .cnt_done (cnt_done)
    );

`ifdef DESER_PARITY_EN
    logic word_par_err;
    // In PAR the core holds, so word is the finished word and ser_in is the parity bit.
    assign deliver      = ser_en && !ser_start && (state == PAR);
    assign word_par_err = ^{word, ser_in};
`else
    assign deliver = cnt_done;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
`ifdef DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // Clear comes first so a same-edge overrun overrides it.
            if (clr_ovr) begin
                overrun <= 1'b0;
            end
            if (deliver) begin
                if (!out_valid || out_ready) begin
                    out_data  <= word;
                    out_valid <= 1'b1;
`ifdef DESER_PARITY_EN
                    parity_err <= word_par_err;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (restart) begin
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (restart) begin
                        frame_err <= 1'b1;
                    end else if (cnt_done) begin
`ifdef DESER_PARITY_EN
                        state <= PAR;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef DESER_PARITY_EN
                PAR: begin
                    if (restart) begin
                        frame_err <= 1'b1;
                        state     <= RECV;
                    end else if (ser_en) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
